// File: rtl/dffn_asr_pipe_if.sv
// Parallel/scan bus of the falling-edge set/reset staging pipeline.
// Latency: none; this only bundles wires.
// Backpressure: none; the pipe has no flow control and always accepts on an enabled edge.
interface dffn_asr_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    logic             EN;
    logic [1:0]       MODE;
    logic [WIDTH-1:0] D;
    logic             DIN_VLD;
    logic             SI;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] QN;
    logic             VLD_OUT;
    logic             SO;
    logic [CNT_W-1:0] OCC;

    // Stimulus side: drives controls and data, observes the last stage.
    modport master (
        output EN, MODE, D, DIN_VLD, SI,
        input  Q, QN, VLD_OUT, SO, OCC
    );

    // Pipeline side.
    modport slave (
        input  EN, MODE, D, DIN_VLD, SI,
        output Q, QN, VLD_OUT, SO, OCC
    );
endinterface

// File: rtl/dffn_asr_pipe.sv
// Falling-edge WIDTH x DEPTH staging pipe with async set (dominant) / reset, hold/shift/clear/scan modes.
// Latency: D captured on falling edge n appears on Q after edge n+DEPTH-1; outputs depend only on state.
// Backpressure: none; EN=0 or MODE=00 simply holds every stage.
module dffn_asr_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic           CLK,
    input  logic           RSTB,
    input  logic           SETB,
    dffn_asr_pipe_if.slave bus
);
    localparam int TOTAL = WIDTH * DEPTH;

    typedef logic [DEPTH-1:0][WIDTH-1:0] stages_t;

    typedef struct packed {
        stages_t          stage;
        logic [DEPTH-1:0] vld;
    } st_t;

    localparam int ST_W = $bits(st_t);

    st_t              st_q;
    st_t              st_d;
    st_t              nxt;
    logic             first;
    logic [2:0]       cand;
    logic [CNT_W-1:0] occ;

    // Next state for one fully-known {en, mode} choice.
    function automatic st_t op_next(
        input logic             en,
        input logic [1:0]       mode,
        input st_t              cur,
        input logic [WIDTH-1:0] d,
        input logic             dvld,
        input logic             si
    );
        st_t              n;
        logic [TOTAL-1:0] flat;
        n    = cur;
        flat = cur.stage;
        if (en) begin
            case (mode)
                2'b01: begin
                    for (int i = DEPTH - 1; i > 0; i--) begin
                        n.stage[i] = cur.stage[i-1];
                        n.vld[i]   = cur.vld[i-1];
                    end
                    n.stage[0] = d;
                    n.vld[0]   = dvld;
                end
                2'b10: n = '0;
                // Whole chain moves one bit toward the last stage's MSB; valid bits untouched.
                2'b11: n.stage = (flat << 1) | TOTAL'(si);
                default: n = cur;
            endcase
        end
        return n;
    endfunction

    // Keep bits that agree between two candidate states, X the ones that differ.
    function automatic st_t merge(input st_t a, input st_t b);
        logic [ST_W-1:0] av;
        logic [ST_W-1:0] bv;
        logic [ST_W-1:0] r;
        av = a;
        bv = b;
        for (int i = 0; i < ST_W; i++) begin
            r[i] = (av[i] === bv[i]) ? av[i] : 1'bx;
        end
        return r;
    endfunction

    // Next state; with unknown EN/MODE, fold every consistent operation together.
    always_comb begin
        st_d  = st_q;
        nxt   = st_q;
        first = 1'b1;
        cand  = 3'b000;
        if (!$isunknown({bus.EN, bus.MODE})) begin
            st_d = op_next(bus.EN, bus.MODE, st_q, bus.D, bus.DIN_VLD, bus.SI);
        end else begin
            for (int c = 0; c < 8; c++) begin
                cand = 3'(c);
                if (((cand[2] === bus.EN)      || $isunknown(bus.EN))      &&
                    ((cand[1] === bus.MODE[1]) || $isunknown(bus.MODE[1])) &&
                    ((cand[0] === bus.MODE[0]) || $isunknown(bus.MODE[0]))) begin
                    nxt   = op_next(cand[2], cand[1:0], st_q, bus.D, bus.DIN_VLD, bus.SI);
                    st_d  = first ? nxt : merge(st_d, nxt);
                    first = 1'b0;
                end
            end
        end
    end

    // Falling-edge state with async set over reset; an edge while either is low does nothing.
    always_ff @(negedge CLK or negedge SETB or negedge RSTB) begin
        if (!SETB) begin
            st_q <= '1;
        end else if ($isunknown(SETB)) begin
            st_q <= (RSTB === 1'b1) ? merge(st_q, '1) : merge(merge(st_q, '0), '1);
        end else if (!RSTB) begin
            st_q <= '0;
        end else if ($isunknown(RSTB)) begin
            st_q <= merge(st_q, '0);
        end else begin
            st_q <= st_d;
        end
    end

    // Occupancy is a popcount of the valid bits, so it cannot drift from them.
    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + CNT_W'(st_q.vld[i]);
        end
    end

    assign bus.Q       = st_q.stage[DEPTH-1];
    assign bus.QN      = ~st_q.stage[DEPTH-1];
    assign bus.VLD_OUT = st_q.vld[DEPTH-1];
    assign bus.SO      = st_q.stage[DEPTH-1][WIDTH-1];
    assign bus.OCC     = occ;
endmodule

// File: tb/tb_dffn_asr_pipe.sv
// Directed bench for dffn_asr_pipe at WIDTH=8, DEPTH=2.
// Inputs change 2 time units after each falling edge; outputs are sampled there too.
// Table-driven shift/hold/clear vectors plus hand sequences for async, scan and unknown-mode cases.
module tb_dffn_asr_pipe;
    logic CLK;
    logic RSTB;
    logic SETB;
    int   n_cmp = 0;
    int   n_err = 0;

    dffn_asr_pipe_if #(.WIDTH(8), .DEPTH(2)) bus ();

    dffn_asr_pipe #(.WIDTH(8), .DEPTH(2)) dut (
        .CLK (CLK),
        .RSTB(RSTB),
        .SETB(SETB),
        .bus (bus.slave)
    );

    initial begin
        CLK = 1'b1;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [7:0] d;
        logic       dv;
        logic [7:0] q;
        logic       v;
        logic [1:0] occ;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] q, input logic v, input logic [1:0] occ);
        logic [7:0] qn;
        qn = ~q;
        chk({tag, ".Q"},       16'(bus.Q),       16'(q));
        chk({tag, ".QN"},      16'(bus.QN),      16'(qn));
        chk({tag, ".VLD_OUT"}, 16'(bus.VLD_OUT), 16'(v));
        chk({tag, ".OCC"},     16'(bus.OCC),     16'(occ));
        chk({tag, ".SO"},      16'(bus.SO),      16'(q[7]));
    endtask

    task automatic tick();
        @(negedge CLK);
        #2;
    endtask

    task automatic shift_in(input logic [7:0] d, input logic dv);
        bus.EN      = 1'b1;
        bus.MODE    = 2'b01;
        bus.D       = d;
        bus.DIN_VLD = dv;
        tick();
    endtask

    task automatic pulse_rst();
        RSTB = 1'b0;
        #1;
        RSTB = 1'b1;
        #1;
    endtask

    logic [15:0] exp_flat;
    logic [15:0] pat;

    initial begin
        //            en    mode   d      dv    q      v     occ
        tbl[0]  = '{1'b1, 2'b01, 8'hA5, 1'b1, 8'h00, 1'b0, 2'd1};
        tbl[1]  = '{1'b1, 2'b01, 8'h3C, 1'b0, 8'hA5, 1'b1, 2'd1};
        tbl[2]  = '{1'b1, 2'b01, 8'h00, 1'b0, 8'h3C, 1'b0, 2'd0};
        tbl[3]  = '{1'b1, 2'b01, 8'h11, 1'b1, 8'h00, 1'b0, 2'd1};
        tbl[4]  = '{1'b1, 2'b01, 8'h22, 1'b1, 8'h11, 1'b1, 2'd2};
        tbl[5]  = '{1'b0, 2'b10, 8'h33, 1'b0, 8'h11, 1'b1, 2'd2};
        tbl[6]  = '{1'b1, 2'b00, 8'h44, 1'b0, 8'h11, 1'b1, 2'd2};
        tbl[7]  = '{1'b1, 2'b10, 8'h55, 1'b1, 8'h00, 1'b0, 2'd0};
        tbl[8]  = '{1'b1, 2'b01, 8'h66, 1'b1, 8'h00, 1'b0, 2'd1};
        tbl[9]  = '{1'b1, 2'b01, 8'h77, 1'b1, 8'h66, 1'b1, 2'd2};
        tbl[10] = '{1'b1, 2'b01, 8'h88, 1'b1, 8'h77, 1'b1, 2'd2};
        tbl[11] = '{1'b0, 2'b01, 8'h99, 1'b0, 8'h77, 1'b1, 2'd2};

        RSTB        = 1'b1;
        SETB        = 1'b1;
        bus.EN      = 1'b0;
        bus.MODE    = 2'b00;
        bus.D       = 8'h00;
        bus.DIN_VLD = 1'b0;
        bus.SI      = 1'b0;

        // Async reset, then set overriding a held reset, then release.
        @(negedge CLK);
        #1;
        RSTB = 1'b0;
        #1;
        chk_out("rst", 8'h00, 1'b0, 2'd0);
        SETB = 1'b0;
        #1;
        chk_out("set_over_rst", 8'hFF, 1'b1, 2'd2);
        RSTB = 1'b1;
        #1;
        SETB = 1'b1;
        #1;
        chk_out("release", 8'hFF, 1'b1, 2'd2);
        bus.EN   = 1'b0;
        bus.MODE = 2'b01;
        bus.D    = 8'h5A;
        tick();
        chk_out("en0_edge", 8'hFF, 1'b1, 2'd2);

        // Shift / hold / clear vectors from an empty pipe.
        pulse_rst();
        for (int i = 0; i < 12; i++) begin
            bus.EN      = tbl[i].en;
            bus.MODE    = tbl[i].mode;
            bus.D       = tbl[i].d;
            bus.DIN_VLD = tbl[i].dv;
            tick();
            chk_out($sformatf("vec%0d", i), tbl[i].q, tbl[i].v, tbl[i].occ);
        end

        // Async reset pulse mid-stream, released before the rising edge.
        pulse_rst();
        shift_in(8'hA1, 1'b1);
        shift_in(8'hB2, 1'b1);
        chk_out("mid_pre", 8'hA1, 1'b1, 2'd2);
        bus.D = 8'hC3;
        RSTB  = 1'b0;
        #1;
        chk_out("mid_rst", 8'h00, 1'b0, 2'd0);
        RSTB = 1'b1;
        @(posedge CLK);
        #1;
        chk_out("mid_rise", 8'h00, 1'b0, 2'd0);
        shift_in(8'hC3, 1'b1);
        chk_out("mid_resume1", 8'h00, 1'b0, 2'd1);
        shift_in(8'h00, 1'b0);
        chk_out("mid_resume2", 8'hC3, 1'b1, 2'd1);

        // Scan: preload stage1=80, stage0=01.
        shift_in(8'h80, 1'b1);
        shift_in(8'h01, 1'b1);
        chk_out("scan_pre", 8'h80, 1'b1, 2'd2);
        bus.MODE = 2'b11;
        bus.SI   = 1'b0;
        tick();
        chk_out("scan_first", 8'h00, 1'b1, 2'd2);
        exp_flat = 16'h0002;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_flat = {exp_flat[14:0], 1'b0};
        end
        chk_out("scan_stage0_view", 8'h02, 1'b1, 2'd2);
        pat = 16'hBEEF;
        for (int i = 0; i < 16; i++) begin
            bus.SI = pat[15-i];
            #1;
            chk($sformatf("scan_so%0d", i), 16'(bus.SO), 16'(exp_flat[15]));
            tick();
            exp_flat = {exp_flat[14:0], pat[15-i]};
        end
        chk_out("scan_beef_hi", 8'hBE, 1'b1, 2'd2);
        shift_in(8'h00, 1'b1);
        chk_out("scan_beef_lo", 8'hEF, 1'b1, 2'd2);

        // Unknown MODE bit: shift and scan candidates agree on zero state.
        pulse_rst();
        bus.EN      = 1'b1;
        bus.MODE    = 2'bx1;
        bus.D       = 8'h00;
        bus.DIN_VLD = 1'b0;
        bus.SI      = 1'b0;
        tick();
        chk_out("x_mode_zero", 8'h00, 1'b0, 2'd0);
        bus.D = 8'hFF;
        tick();
        chk_out("x_mode_ff_last", 8'h00, 1'b0, 2'd0);
        bus.MODE = 2'b10;
        tick();
        chk_out("x_then_clear", 8'h00, 1'b0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
